// File: rtl/spi_frame_reader_if.sv
// Request/response and SPI pin bundle for spi_frame_reader.
// The slave modport is the reader itself; the master side is the requester plus the flash.
interface spi_frame_reader_if #(
    parameter int DATA_BITS  = 8192,
    parameter int MAX_FRAMES = 4
);
    logic                    start;
    logic [3:0]              frame_count;
    logic [8*MAX_FRAMES-1:0] frames;
    logic [1:0]              mode;
    logic                    busy;
    logic                    done;
    logic [DATA_BITS-1:0]    data;
    logic                    spi_cs_n;
    logic                    spi_sck;
    logic                    spi_mosi;
    logic                    spi_miso;

    modport master (
        output start, frame_count, frames, mode, spi_miso,
        input  busy, done, data, spi_cs_n, spi_sck, spi_mosi
    );

    modport slave (
        input  start, frame_count, frames, mode, spi_miso,
        output busy, done, data, spi_cs_n, spi_sck, spi_mosi
    );
endinterface

// File: rtl/spi_frame_reader.sv
// Fetches up to MAX_FRAMES frames from SPI flash with READ commands and merges
// them into one DATA_BITS word (replace / OR / XOR). SCK is a divided register.
//
// state  | meaning
// IDLE   | waiting for start; cs_n high
// CMD    | cs_n low, shifting opcode + 24-bit address out on MOSI
// DATA   | cs_n low, shifting DATA_BITS bits in from MISO
// GAP    | cs_n high between frames for GAP_CYCLES
module spi_frame_reader #(
    parameter int          DATA_BITS  = 8192,
    parameter int          MAX_FRAMES = 4,
    parameter int          CLK_DIV    = 1,
    parameter int          GAP_CYCLES = 2,
    parameter logic [7:0]  CMD        = 8'h03,
    parameter logic [23:0] BASE_ADDR  = 24'h000000
) (
    input logic             clk,
    input logic             rst_n,
    spi_frame_reader_if.slave bus
);

    localparam int FW = 8 * MAX_FRAMES;
    localparam int BW = $clog2(DATA_BITS + 32);
    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_GAP} state_t;

    state_t               state;
    logic                 cs_n_q;
    logic                 sck_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 first_q;
    logic [1:0]           mode_q;
    logic [3:0]           remain_q;
    logic [FW-1:0]        frames_q;
    logic [31:0]          cmd_sr;
    logic [BW-1:0]        bit_cnt;
    logic [HW-1:0]        half_cnt;
    logic [GW-1:0]        gap_cnt;
    logic [DATA_BITS-1:0] staging_q;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] merged;
    logic [3:0]           count_clamp;

    function automatic logic [23:0] frame_addr(input logic [7:0] idx);
        logic [31:0] a;
        a = 32'(BASE_ADDR) + 32'(idx) * 32'(DATA_BITS / 8);
        return a[23:0];
    endfunction

    always_comb begin
        count_clamp = bus.frame_count;
        if (bus.frame_count > 4'(MAX_FRAMES))
            count_clamp = 4'(MAX_FRAMES);
    end

    // The first frame of a request always replaces, whatever the mode.
    always_comb begin
        merged = staging_q;
        if (!first_q) begin
            case (mode_q)
                2'b00:   merged = staging_q;
                2'b10:   merged = data_q ^ staging_q;
                default: merged = data_q | staging_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            first_q   <= 1'b0;
            mode_q    <= '0;
            remain_q  <= '0;
            frames_q  <= '0;
            cmd_sr    <= '0;
            bit_cnt   <= '0;
            half_cnt  <= '0;
            gap_cnt   <= '0;
            staging_q <= '0;
            data_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q   <= bus.mode;
                        frames_q <= bus.frames;
                        if (count_clamp == 4'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            remain_q <= count_clamp - 4'd1;
                            busy_q   <= 1'b1;
                            first_q  <= 1'b1;
                            cs_n_q   <= 1'b0;
                            sck_q    <= 1'b0;
                            half_cnt <= HW'(CLK_DIV - 1);
                            cmd_sr   <= {CMD, frame_addr(bus.frames[7:0])};
                            bit_cnt  <= BW'(31);
                            state    <= S_CMD;
                        end
                    end
                end
                S_CMD, S_DATA: begin
                    if (half_cnt != '0) begin
                        half_cnt <= half_cnt - HW'(1);
                    end else begin
                        half_cnt <= HW'(CLK_DIV - 1);
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (state == S_DATA)
                                staging_q <= {staging_q[DATA_BITS-2:0], bus.spi_miso};
                        end else begin
                            sck_q <= 1'b0;
                            // MOSI is cmd_sr[31]; the shift after the last address bit leaves it 0.
                            if (state == S_CMD)
                                cmd_sr <= {cmd_sr[30:0], 1'b0};
                            if (bit_cnt != '0) begin
                                bit_cnt <= bit_cnt - BW'(1);
                            end else if (state == S_CMD) begin
                                bit_cnt <= BW'(DATA_BITS - 1);
                                state   <= S_DATA;
                            end else begin
                                cs_n_q   <= 1'b1;
                                data_q   <= merged;
                                first_q  <= 1'b0;
                                frames_q <= frames_q >> 8;
                                if (remain_q == 4'd0) begin
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                    state  <= S_IDLE;
                                end else begin
                                    remain_q <= remain_q - 4'd1;
                                    gap_cnt  <= GW'(GAP_CYCLES - 1);
                                    state    <= S_GAP;
                                end
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else begin
                        cs_n_q   <= 1'b0;
                        sck_q    <= 1'b0;
                        half_cnt <= HW'(CLK_DIV - 1);
                        cmd_sr   <= {CMD, frame_addr(frames_q[7:0])};
                        bit_cnt  <= BW'(31);
                        state    <= S_CMD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data     = data_q;
    assign bus.spi_cs_n = cs_n_q;
    assign bus.spi_sck  = sck_q;
    assign bus.spi_mosi = cmd_sr[31];

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed bench for spi_frame_reader: table of requests on a CLK_DIV=1 instance,
// hand sequences for the corner cases, and a CLK_DIV=3 / wrapped-address instance.
module tb_spi_frame_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_frame_reader_if #(.DATA_BITS(32), .MAX_FRAMES(4)) ifa ();
    spi_frame_reader_if #(.DATA_BITS(32), .MAX_FRAMES(4)) ifb ();

    spi_frame_reader #(.DATA_BITS(32), .MAX_FRAMES(4), .CLK_DIV(1), .GAP_CYCLES(2),
                       .CMD(8'h03), .BASE_ADDR(24'h000000))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

    spi_frame_reader #(.DATA_BITS(32), .MAX_FRAMES(4), .CLK_DIV(3), .GAP_CYCLES(2),
                       .CMD(8'h03), .BASE_ADDR(24'hFFFFF0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Flash model + monitor for instance A (sole writer of its variables and of ifa.spi_miso)
    logic [31:0] img_a [256];
    int          lowlens_a [$];
    int          gaps_a [$];
    logic [31:0] cmds_a [$];
    int          a_low_run = 0, a_hi_run = 0, a_done = 0, a_busy = 0, a_fb = 0;
    logic        a_psck = 1'b0;
    logic [31:0] a_cmd = '0, a_word = '0;

    always @(negedge clk) begin
        if (!ifa.spi_cs_n) a_low_run++;
        else if (a_low_run > 0) begin lowlens_a.push_back(a_low_run); a_low_run = 0; end
        if (ifa.spi_cs_n && ifa.busy) a_hi_run++;
        else if (a_hi_run > 0) begin gaps_a.push_back(a_hi_run); a_hi_run = 0; end
        if (ifa.done) a_done++;
        if (ifa.busy) a_busy++;
        if (ifa.spi_cs_n) begin
            a_fb = 0;
            ifa.spi_miso = 1'b0;
        end else if (ifa.spi_sck && !a_psck && a_fb < 32) begin
            a_cmd = {a_cmd[30:0], ifa.spi_mosi};
            a_fb++;
            if (a_fb == 32) begin cmds_a.push_back(a_cmd); a_word = img_a[a_cmd[9:2]]; end
        end else if (!ifa.spi_sck && a_psck && a_fb == 32) begin
            ifa.spi_miso = a_word[31];
            a_word = {a_word[30:0], 1'b0};
        end
        a_psck = ifa.spi_sck;
    end

    // Flash model + monitor for instance B, including SCK phase lengths
    logic [31:0] img_b = 32'h3C3CA5F0;
    int          lowlens_b [$];
    logic [31:0] cmds_b [$];
    int          b_low_run = 0, b_done = 0, b_busy = 0, b_fb = 0;
    int          b_shi = 0, b_slo = 0, b_hi_min = 999, b_hi_max = 0, b_lo_min = 999, b_lo_max = 0;
    logic        b_psck = 1'b0;
    logic [31:0] b_cmd = '0, b_word = '0;

    always @(negedge clk) begin
        if (!ifb.spi_cs_n) b_low_run++;
        else if (b_low_run > 0) begin lowlens_b.push_back(b_low_run); b_low_run = 0; end
        if (!ifb.spi_cs_n && ifb.spi_sck) b_shi++;
        else if (b_shi > 0) begin
            if (b_shi < b_hi_min) b_hi_min = b_shi;
            if (b_shi > b_hi_max) b_hi_max = b_shi;
            b_shi = 0;
        end
        if (!ifb.spi_cs_n && !ifb.spi_sck) b_slo++;
        else if (b_slo > 0) begin
            if (b_slo < b_lo_min) b_lo_min = b_slo;
            if (b_slo > b_lo_max) b_lo_max = b_slo;
            b_slo = 0;
        end
        if (ifb.done) b_done++;
        if (ifb.busy) b_busy++;
        if (ifb.spi_cs_n) begin
            b_fb = 0;
            ifb.spi_miso = 1'b0;
        end else if (ifb.spi_sck && !b_psck && b_fb < 32) begin
            b_cmd = {b_cmd[30:0], ifb.spi_mosi};
            b_fb++;
            if (b_fb == 32) begin cmds_b.push_back(b_cmd); b_word = img_b; end
        end else if (!ifb.spi_sck && b_psck && b_fb == 32) begin
            ifb.spi_miso = b_word[31];
            b_word = {b_word[30:0], 1'b0};
        end
        b_psck = ifb.spi_sck;
    end

    typedef struct {
        logic [3:0]       cnt;
        logic [31:0]      frames;
        logic [1:0]       mode;
        logic [3:0][31:0] d;
        logic [31:0]      exp_data;
        int               exp_txn;
        int               exp_busy;
    } vec_t;

    vec_t vt [7];

    function automatic vec_t mk(input logic [3:0] cnt, input logic [31:0] fr, input logic [1:0] md,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [31:0] ed, input int txn, input int bsy);
        vec_t v;
        v.cnt = cnt; v.frames = fr; v.mode = md;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.exp_data = ed; v.exp_txn = txn; v.exp_busy = bsy;
        return v;
    endfunction

    task automatic wait_done_a(input string name);
        int t;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (ifa.done) break;
        end
        if (t == 3000) begin
            n_chk++; n_fail++;
            $display("FAIL %s: done never seen within %0d cycles", name, t);
        end
        repeat (2) @(negedge clk);
    endtask

    // Inputs are scrambled right after acceptance; the latched copies must be used.
    task automatic issue_a(input logic [3:0] cnt, input logic [31:0] fr, input logic [1:0] md,
                           input bit wait_done);
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.frame_count = cnt; ifa.frames = fr; ifa.mode = md;
        @(posedge clk); #1;
        ifa.start = 1'b0; ifa.frame_count = ~cnt; ifa.frames = ~fr; ifa.mode = ~md;
        if (wait_done) wait_done_a("done_wait");
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int nf, s_low, s_gap, s_cmd, s_done, s_busy;
        logic [7:0] idx;
        v = vt[i];
        nf = (v.cnt > 4) ? 4 : int'(v.cnt);
        for (int k = 0; k < nf; k++) img_a[v.frames[8*k +: 8]] = v.d[k];
        s_low = lowlens_a.size(); s_gap = gaps_a.size(); s_cmd = cmds_a.size();
        s_done = a_done; s_busy = a_busy;
        issue_a(v.cnt, v.frames, v.mode, 1'b1);
        chk($sformatf("v%0d data", i), ifa.data, v.exp_data);
        chk($sformatf("v%0d done_count", i), a_done - s_done, 1);
        chk($sformatf("v%0d busy_cycles", i), a_busy - s_busy, v.exp_busy);
        chk($sformatf("v%0d transactions", i), lowlens_a.size() - s_low, v.exp_txn);
        chk($sformatf("v%0d commands", i), cmds_a.size() - s_cmd, v.exp_txn);
        chk($sformatf("v%0d gap_count", i), gaps_a.size() - s_gap, v.exp_txn - 1);
        for (int k = 0; k < v.exp_txn && s_cmd + k < cmds_a.size(); k++) begin
            idx = v.frames[8*k +: 8];
            chk($sformatf("v%0d cmd%0d", i, k), cmds_a[s_cmd + k], {8'h03, 24'(idx) * 24'd4});
            chk($sformatf("v%0d cs_low%0d", i, k), lowlens_a[s_low + k], 128);
        end
        for (int k = s_gap; k < gaps_a.size(); k++)
            chk($sformatf("v%0d gap%0d", i, k - s_gap), gaps_a[k], 2);
    endtask

    initial begin
        int s_low, s_cmd, s_done, s_busy, t;

        vt[0] = mk(4'd1, 32'h00000002, 2'b00, 32'hA5A5A5A5, 0, 0, 0, 32'hA5A5A5A5, 1, 128);
        vt[1] = mk(4'd3, 32'h00030201, 2'b01, 32'h0000000F, 32'h000000F0, 32'h0F000000, 0,
                   32'h0F0000FF, 3, 388);
        vt[2] = mk(4'd2, 32'h00000605, 2'b10, 32'hFFFF0000, 32'hFFFF0000, 0, 0, 32'h00000000, 2, 258);
        vt[3] = mk(4'd2, 32'h00000807, 2'b00, 32'h12345678, 32'h9ABCDEF0, 0, 0, 32'h9ABCDEF0, 2, 258);
        vt[4] = mk(4'd2, 32'h00000A09, 2'b11, 32'hF0F0F0F0, 32'h0000FFFF, 0, 0, 32'hF0F0FFFF, 2, 258);
        vt[5] = mk(4'd9, 32'h0E0D0C0B, 2'b10, 32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888,
                   32'hFFFFFFFF, 4, 518);
        vt[6] = mk(4'd1, 32'h000000FF, 2'b01, 32'hAAAA5555, 0, 0, 0, 32'hAAAA5555, 1, 128);
        for (int k = 0; k < 256; k++) img_a[k] = 32'h0;

        ifa.start = 1'b0; ifa.frame_count = '0; ifa.frames = '0; ifa.mode = '0;
        ifb.start = 1'b0; ifb.frame_count = '0; ifb.frames = '0; ifb.mode = '0;

        repeat (3) @(negedge clk);
        chk("rst cs_n", ifa.spi_cs_n, 1'b1);
        chk("rst sck", ifa.spi_sck, 1'b0);
        chk("rst mosi", ifa.spi_mosi, 1'b0);
        chk("rst busy", ifa.busy, 1'b0);
        chk("rst done", ifa.done, 1'b0);
        chk("rst data", ifa.data, 32'h0);
        chk("rst b cs_n", ifb.spi_cs_n, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) run_vec(i);

        // Zero-count request: done next cycle, no SPI activity, data untouched
        s_low = lowlens_a.size();
        @(posedge clk); #1;
        ifa.start = 1'b1; ifa.frame_count = 4'd0; ifa.frames = 32'h00000001; ifa.mode = 2'b00;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        chk("zero done", ifa.done, 1'b1);
        chk("zero busy", ifa.busy, 1'b0);
        chk("zero cs_n", ifa.spi_cs_n, 1'b1);
        @(posedge clk); #1;
        chk("zero done_pulse", ifa.done, 1'b0);
        repeat (5) @(negedge clk);
        chk("zero no_txn", lowlens_a.size() - s_low, 0);
        chk("zero data", ifa.data, 32'h0);

        for (int i = 3; i < 7; i++) run_vec(i);

        // Start while busy must be ignored
        img_a[1] = 32'h11112222; img_a[2] = 32'hCAFEF00D;
        s_low = lowlens_a.size(); s_cmd = cmds_a.size(); s_done = a_done; s_busy = a_busy;
        issue_a(4'd2, 32'h00000201, 2'b00, 1'b0);
        repeat (50) @(negedge clk);
        ifa.start = 1'b1; ifa.frame_count = 4'd1; ifa.frames = 32'h00000030; ifa.mode = 2'b10;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        wait_done_a("ignored_start");
        chk("ign data", ifa.data, 32'hCAFEF00D);
        chk("ign txn", lowlens_a.size() - s_low, 2);
        chk("ign busy", a_busy - s_busy, 258);
        chk("ign done", a_done - s_done, 1);
        if (cmds_a.size() - s_cmd == 2) begin
            chk("ign cmd0", cmds_a[s_cmd], 32'h03000004);
            chk("ign cmd1", cmds_a[s_cmd + 1], 32'h03000008);
        end else begin
            chk("ign cmd_count", cmds_a.size() - s_cmd, 2);
        end

        // Reset mid-DATA
        img_a[3] = 32'hDEADBEEF;
        issue_a(4'd1, 32'h00000003, 2'b00, 1'b0);
        repeat (80) @(negedge clk);
        chk("rst_mid in_frame", ifa.spi_cs_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid cs_n", ifa.spi_cs_n, 1'b1);
        chk("rst_mid sck", ifa.spi_sck, 1'b0);
        chk("rst_mid busy", ifa.busy, 1'b0);
        chk("rst_mid data", ifa.data, 32'h0);
        chk("rst_mid mosi", ifa.spi_mosi, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        img_a[3] = 32'h5A5A1234;
        s_cmd = cmds_a.size();
        issue_a(4'd1, 32'h00000003, 2'b01, 1'b1);
        chk("post_rst data", ifa.data, 32'h5A5A1234);
        if (cmds_a.size() > s_cmd) chk("post_rst cmd", cmds_a[s_cmd], 32'h0300000C);
        else chk("post_rst cmd_count", cmds_a.size() - s_cmd, 1);

        // Divider 3 and address wrap: 0xFFFFF0 + 4*4 -> 0x000000
        s_low = lowlens_b.size(); s_cmd = cmds_b.size(); s_done = b_done; s_busy = b_busy;
        @(posedge clk); #1;
        ifb.start = 1'b1; ifb.frame_count = 4'd1; ifb.frames = 32'h00000004; ifb.mode = 2'b00;
        @(posedge clk); #1;
        ifb.start = 1'b0; ifb.frames = 32'hFFFFFFFF;
        for (t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (ifb.done) break;
        end
        if (t == 2000) begin
            n_chk++; n_fail++;
            $display("FAIL div done_wait: done never seen within %0d cycles", t);
        end
        repeat (2) @(negedge clk);
        chk("div data", ifb.data, 32'h3C3CA5F0);
        chk("div done", b_done - s_done, 1);
        chk("div busy", b_busy - s_busy, 384);
        if (lowlens_b.size() - s_low == 1) chk("div cs_low", lowlens_b[s_low], 384);
        else chk("div txn", lowlens_b.size() - s_low, 1);
        if (cmds_b.size() - s_cmd == 1) chk("div cmd", cmds_b[s_cmd], 32'h03000000);
        else chk("div cmd_count", cmds_b.size() - s_cmd, 1);
        chk("div sck_hi_min", b_hi_min, 3);
        chk("div sck_hi_max", b_hi_max, 3);
        chk("div sck_lo_min", b_lo_min, 3);
        chk("div sck_lo_max", b_lo_max, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_reader.md
# spi_frame_reader

Parametrised SPI-flash frame fetcher that drives the display frame buffer. On a `start` pulse it issues one READ (0x03) transaction per requested frame index and shifts `DATA_BITS` bits per frame from flash. It merges successive frames into `data` by replace, OR or XOR. SCK comes from a clock divider, not a gated clock, and the block reports completion through a `busy`/`done` handshake.

## Interface

Parameters:
- `DATA_BITS`, 8192: bits per frame; multiple of 8, ≥ 8.
- `MAX_FRAMES`, 4: maximum frames per request (1–15).
- `CLK_DIV`, 1: SCK half-period in `clk` cycles (≥ 1).
- `GAP_CYCLES`, 2: minimum cs_n-high time between frames, in `clk` cycles (≥ 1).
- `CMD`, 8'h03: flash read opcode.
- `BASE_ADDR`, 24'h000000: flash byte address of frame index 0.

Ports:
- `clk`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request pulse; honoured only when `busy`=0.
- `frame_count`  in  4: number of frames to fetch; values above `MAX_FRAMES` are clamped to `MAX_FRAMES`.
- `frames`  in  8*MAX_FRAMES: frame indices; frame k uses `frames[8k+:8]`.
- `mode`  in  2: merge mode. 00 replace, 01 OR, 10 XOR, 11 treated as OR.
- `busy`  out  1: high from the accepted start until done.
- `done`  out  1: one-cycle pulse at request completion.
- `data`  out  DATA_BITS: merged frame; MSB is the first bit received.
- `spi_cs_n`  out  1: flash chip select, active low.
- `spi_sck`  out  1: SPI clock, mode 0 (idle low).
- `spi_mosi`  out  1: command/address, MSB first.
- `spi_miso`  in  1: flash data.

## Operation

- States: IDLE, CMD, DATA, GAP.
- IDLE, on `start`=1:
  - Latch `frame_count` (clamped), `frames` and `mode`.
  - If the clamped count = 0: pulse `done`, stay in IDLE, leave `data` unchanged, make no SPI activity.
  - Otherwise: `busy`=1, frame index k=0, enter CMD.
- CMD:
  - cs_n low.
  - Shift 32 bits: `CMD` then a 24-bit address.
  - Address = `BASE_ADDR` + index*(DATA_BITS/8), truncated to 24 bits (wraps mod 2^24).
- DATA:
  - Shift `DATA_BITS` bits from `spi_miso` into an internal staging register, MSB first.
- At the end of each frame:
  - cs_n goes high.
  - Frame 0: `data` ← staging.
  - Frames 1 and later: `data` ← `data` OP staging, where OP is set by the latched mode (replace, OR or XOR).
  - If k < count−1: go to GAP, wait `GAP_CYCLES`, k←k+1, then CMD.
  - If this was the last frame: go to IDLE, pulse `done`, set `busy`=0.
- `data` changes only at frame end, so it is stable during a transfer.
- `start` while `busy`=1 is ignored. Input changes after acceptance have no effect.
- `rst_n` low at any time, including mid-transfer: all outputs go to their reset values immediately, the state goes to IDLE and the staging register clears. No partial frame is merged.

## Timing

- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `busy`=0, `done`=0, `data`=0.
- Let D=`CLK_DIV`.
- Start accepted at edge E0:
  - `busy`=1 and `spi_cs_n`=0 after E0.
  - `spi_mosi` presents CMD bit 7 from the same edge.
- Bit timing:
  - SCK first rises D cycles after cs_n falls.
  - Each bit lasts 2D cycles.
  - MOSI changes only on SCK falling edges (or at cs_n fall for the first bit).
  - MISO is sampled on the `clk` edge at which SCK goes 0→1.
- Per frame, cs_n is low for exactly (32+DATA_BITS)·2D cycles. cs_n rises on the edge that ends the final SCK low phase, and SCK is 0 at that point.
- Between frames, cs_n stays high for exactly `GAP_CYCLES`.
- The `data` update, `done`=1 and `busy`=0 all take effect on the same edge as the final cs_n rise.
- Request latency: N·(32+DATA_BITS)·2D + (N−1)·GAP_CYCLES cycles from E0, for N frames.
- A new `start` is accepted on the cycle after `done` at the earliest.

## Test plan

Common setup unless stated: DATA_BITS=32, MAX_FRAMES=4, CLK_DIV=1, GAP_CYCLES=2, BASE_ADDR=0.

- **Single-frame replace:** mode=00, count=1, frames[7:0]=8'h02, MISO model returns 32'hA5A5A5A5 → MOSI carries 32'h03000008; cs_n low exactly 128 cycles; `data`=32'hA5A5A5A5; exactly one `done`.
- **OR accumulate:** count=3, mode=01, frames carry 0x0000000F, 0x000000F0, 0x0F000000 → `data`=32'h0F0000FF; two cs_n-high gaps of 2 cycles; total busy time 3·128+2·2=388 cycles.
- **XOR mode:** count=2, both frames return 32'hFFFF0000 → `data`=0. Then count=0 → `done` on the next cycle, cs_n never low, `data` stays 0.
- **Clamp and address wrap:** count=9 with MAX_FRAMES=4 → exactly 4 transactions. With BASE_ADDR=24'hFFFFF0 and index 4 → address 24'h000000.
- **Ignored start and mid-transfer reset:** `start` pulsed while busy is ignored (no restart, address sequence unchanged). `rst_n` pulsed low mid-DATA → cs_n=1, sck=0, busy=0, data=0 immediately. The next start completes normally with correct data.
- **Divider:** CLK_DIV=3, single frame → each SCK half-period is 3 cycles; cs_n low 384 cycles; data correct.
